// File: rtl/add_mul_top.sv
// Registered 32-bit adder / 20x20 multiplier datapath with a 40-bit result.
// VARIANT picks the adder cell used everywhere: 1 ripple, 2 CLA-4, 3 carry-select-8.

module add_mul_adder #(
  parameter int unsigned W       = 32,
  parameter int unsigned VARIANT = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   sum_o
);

  // Carries live in per-bit/per-group scopes so each link of the chain is its own net.
  if (VARIANT == 1) begin : g_rca
    for (genvar i = 0; i < W; i++) begin : g_bit
      logic ci, co;
      if (i == 0) begin : g_c0
        assign ci = 1'b0;
      end else begin : g_cn
        assign ci = g_bit[i-1].co;
      end
      assign sum_o[i] = a_i[i] ^ b_i[i] ^ ci;
      assign co       = (a_i[i] & b_i[i]) | (ci & (a_i[i] ^ b_i[i]));
    end
    assign sum_o[W] = g_bit[W-1].co;

  end else if (VARIANT == 2 && (W % 4) == 0) begin : g_cla
    localparam int unsigned NG = W / 4;
    for (genvar k = 0; k < NG; k++) begin : g_grp
      logic [3:0] g, p, c;
      logic       cin, cout;
      if (k == 0) begin : g_c0
        assign cin = 1'b0;
      end else begin : g_cn
        assign cin = g_grp[k-1].cout;
      end
      assign g = a_i[4*k +: 4] & b_i[4*k +: 4];
      assign p = a_i[4*k +: 4] ^ b_i[4*k +: 4];
      assign c[0] = cin;
      assign c[1] = g[0] | (p[0] & cin);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & cin);
      assign sum_o[4*k +: 4] = p ^ c;
    end
    assign sum_o[W] = g_grp[NG-1].cout;

  end else if (VARIANT == 3) begin : g_csel
    localparam int unsigned NB = (W + 7) / 8;
    for (genvar k = 0; k < NB; k++) begin : g_blk
      localparam int unsigned LO = 8 * k;
      localparam int unsigned BW = ((W - LO) < 8) ? (W - LO) : 8;
      logic cin, cout;
      if (k == 0) begin : g_c0
        assign cin = 1'b0;
      end else begin : g_cn
        assign cin = g_blk[k-1].cout;
      end
      // Both carry-in hypotheses ripple in parallel; the real block carry picks one.
      for (genvar j = 0; j < BW; j++) begin : g_bit
        logic p, g, c0i, c1i, c0o, c1o;
        assign p = a_i[LO+j] ^ b_i[LO+j];
        assign g = a_i[LO+j] & b_i[LO+j];
        if (j == 0) begin : g_c0
          assign c0i = 1'b0;
          assign c1i = 1'b1;
        end else begin : g_cn
          assign c0i = g_bit[j-1].c0o;
          assign c1i = g_bit[j-1].c1o;
        end
        assign c0o = g | (p & c0i);
        assign c1o = g | (p & c1i);
        assign sum_o[LO+j] = cin ? (p ^ c1i) : (p ^ c0i);
      end
      assign cout = cin ? g_bit[BW-1].c1o : g_bit[BW-1].c0o;
    end
    assign sum_o[W] = g_blk[NB-1].cout;

  end else begin : g_bad
    $error("add_mul_adder: illegal VARIANT %0d for width %0d", VARIANT, W);
  end

endmodule

module add_mul_top #(
  parameter int unsigned VARIANT = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        Sel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [39:0] Result
);

  localparam int unsigned OP_W  = 32;
  localparam int unsigned MUL_W = 20;
  localparam int unsigned RES_W = 40;

  if (VARIANT < 1 || VARIANT > 3) begin : g_bad_variant
    $error("add_mul_top: VARIANT must be 1, 2 or 3 (got %0d)", VARIANT);
  end

  logic [OP_W:0]    sum;
  logic [RES_W-1:0] prod;
  logic [RES_W-1:0] result_d, result_q;

  add_mul_adder #(.W(OP_W), .VARIANT(VARIANT)) u_add (
    .a_i   (A),
    .b_i   (B),
    .sum_o (sum)
  );

  // Stage i holds (sum of partial products 0..i) >> i; its LSB is final product bit i.
  for (genvar i = 0; i < MUL_W; i++) begin : g_stage
    logic [MUL_W-1:0] pp;
    logic [MUL_W:0]   r;
    assign pp = A[MUL_W-1:0] & {MUL_W{B[i]}};
    if (i == 0) begin : g_first
      assign r = {1'b0, pp};
    end else begin : g_acc
      add_mul_adder #(.W(MUL_W), .VARIANT(VARIANT)) u_acc (
        .a_i   (g_stage[i-1].r[MUL_W:1]),
        .b_i   (pp),
        .sum_o (r)
      );
    end
    if (i < MUL_W - 1) begin : g_lsb
      assign prod[i] = r[0];
    end else begin : g_top
      assign prod[RES_W-1:MUL_W-1] = r;
    end
  end

  always_comb begin
    result_d = RES_W'(sum);
    if (Sel) result_d = prod;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) result_q <= '0;
    else       result_q <= result_d;
  end

  assign Result = result_q;

endmodule

// File: tb/tb_add_mul_top.sv
// Scoreboard bench: all three adder variants side by side against a behavioural model.

module tb_add_mul_top;

  logic        clk;
  logic        nrst;
  logic        Sel;
  logic [31:0] A, B;
  logic [39:0] res1, res2, res3;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [39:0] exp_q[$];

  add_mul_top #(.VARIANT(1)) u_v1 (.clk(clk), .nrst(nrst), .Sel(Sel), .A(A), .B(B), .Result(res1));
  add_mul_top #(.VARIANT(2)) u_v2 (.clk(clk), .nrst(nrst), .Sel(Sel), .A(A), .B(B), .Result(res2));
  add_mul_top #(.VARIANT(3)) u_v3 (.clk(clk), .nrst(nrst), .Sel(Sel), .A(A), .B(B), .Result(res3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [39:0] a_ext, b_ext;
    if (s) begin
      a_ext = 40'(a[19:0]);
      b_ext = 40'(b[19:0]);
      return a_ext * b_ext;
    end
    a_ext = 40'(a);
    b_ext = 40'(b);
    return a_ext + b_ext;
  endfunction

  task automatic check_all(input string tag, input logic [39:0] exp);
    check_eq({tag, "/v1"}, res1, exp);
    check_eq({tag, "/v2"}, res2, exp);
    check_eq({tag, "/v3"}, res3, exp);
  endtask

  // Called just after a rising edge: drive, push expectation, then compare after the next edge.
  task automatic step(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [39:0] e;
    Sel = s;
    A   = a;
    B   = b;
    exp_q.push_back(model(s, a, b));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "/queue"}, 40'h1, 40'h0);
    end else begin
      e = exp_q.pop_front();
      check_all(tag, e);
    end
  endtask

  initial begin
    nrst = 1'b1;
    Sel  = 1'b0;
    A    = 32'd5;
    B    = 32'd7;
    #2 nrst = 1'b0;
    #1 check_all("rst_async", 40'h0);
    repeat (2) @(posedge clk);
    #1 check_all("rst_hold", 40'h0);
    @(negedge clk);
    nrst = 1'b1;
    #1 check_all("rst_release", 40'h0);
    @(posedge clk);
    #1 check_all("first_edge", 40'd12);

    step("add_10_0",    1'b0, 32'd10, 32'd0);
    step("add_0_0",     1'b0, 32'd0, 32'd0);
    step("add_10_10",   1'b0, 32'd10, 32'd10);
    step("add_150_120", 1'b0, 32'd150, 32'd120);
    step("add_carry",   1'b0, 32'hFFFF_FFFF, 32'd1);
    step("add_max",     1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step("mul_0_0",     1'b1, 32'd0, 32'd0);
    step("mul_10_10",   1'b1, 32'd10, 32'd10);
    step("mul_150_120", 1'b1, 32'd150, 32'd120);
    step("mul_upper",   1'b1, 32'hFFFF_FFFF, 32'd1);
    step("mul_max",     1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step("sw_add",      1'b0, 32'd10, 32'd0);
    step("sw_mul",      1'b1, 32'd0, 32'd0);
    step("hold_a",      1'b1, 32'd1234, 32'd4321);
    step("hold_b",      1'b1, 32'd1234, 32'd4321);

    // Reset pulse between edges while a nonzero result is held.
    Sel = 1'b1;
    A   = 32'd3;
    B   = 32'd4;
    #1 nrst = 1'b0;
    #1 check_all("rst_mid", 40'h0);
    #4 nrst = 1'b1;
    #1 check_all("rst_mid_rel", 40'h0);
    @(posedge clk);
    #1 check_all("rst_mid_edge", 40'd12);

    for (int i = 0; i < 10000; i++) begin
      step("rand", 1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_mul_top.md
# add_mul_top

Registered 32-bit adder / 20-bit multiplier datapath with a 40-bit result, selected per cycle by `Sel`. It is the top-level wrapper of the adder/multiplier homework datapath. The `Top_1`, `Top_2` and `Top_3` comparison instances are this block with `VARIANT` = 1, 2 and 3. All variants are functionally identical cycle-for-cycle; they differ only in internal adder architecture.

## Interface
- `VARIANT`, default 1. Selects the internal adder architecture.
  - 1 = ripple-carry.
  - 2 = carry-lookahead, 4-bit groups.
  - 3 = carry-select, 8-bit blocks.
  - Any other value is illegal; elaboration must fail.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `nrst`  in  1  reset, asynchronous and active-low.
- `Sel`  in  1  operation select: 0 = add, 1 = multiply.
- `A`  in  32  operand A, unsigned.
- `B`  in  32  operand B, unsigned.
- `Result`  out  40  registered result, unsigned.

## Operation
- **Add (`Sel`=0).** Compute the full 33-bit unsigned sum A+B.
  - Result[32:0] = sum; Result[39:33] = 0.
  - The carry-out lands in Result[32]; nothing wraps or saturates.
- **Multiply (`Sel`=1).** Compute the unsigned product A[19:0] × B[19:0], which is exactly 40 bits.
  - A[31:20] and B[31:20] are ignored.
- **Multiplier structure.** 20 AND-gated partial products, shifted and accumulated combinationally.
  - Accumulation uses the same adder architecture selected by `VARIANT`.
  - The HDL `*` and `+` operators on full-width operands are not allowed; the adder cells are built structurally (full adders / generate-propagate logic).
- **Inputs.** `A`, `B` and `Sel` are sampled only at the rising edge. The combinational datapath between edges has no architectural effect.
- **Unknowns.** X/Z on operands propagates to `Result`; no special handling.
- **Variant equivalence.** All three variants produce bit-identical `Result` for every input sequence.

## Timing
- **Reset.** While `nrst`=0, `Result` = 40'h0, asynchronously (no clock needed). This includes reset asserted mid-operation.
- **Reset release.** On deassertion, `Result` holds 0 until the first rising edge at which `nrst`=1.
- **Latency.** Exactly 1 cycle. At every rising edge with `nrst`=1, `Result` <= f(`Sel`, `A`, `B`) using the values present just before that edge.
- **Throughput.** One new operation per cycle. No handshake, no valid/ready, no stall.
- **`Sel` changes.** A change of `Sel` takes effect at the same edge as the operands sampled with it; there is no mode-switch bubble.
- **Holding.** Holding inputs constant holds `Result` constant.
- **Closure.** The combinational path (20-term multiply accumulate) must close at the 10 ns clock period used on the bench. Variants 2 and 3 are expected to be faster than variant 1; this is not functionally checked.

## Test plan
- **Reset.** Hold `nrst`=0 for 5 ns mid-cycle with arbitrary inputs.
  - -> `Result` goes to 0 immediately and stays 0 until the first edge after release.
- **Add basics (`Sel`=0).**
  - A=10, B=0 -> 10.
  - A=0, B=0 -> 0.
  - A=10, B=10 -> 20.
  - A=150, B=120 -> 270.
  - Each appears one edge after the operands are applied.
- **Add carry-out (`Sel`=0).** A=32'hFFFFFFFF, B=1 -> `Result`=40'h01_0000_0000 (carry in bit 32, upper bits 0).
- **Multiply (`Sel`=1).**
  - A=0, B=0 -> 0.
  - A=10, B=10 -> 100.
  - A=150, B=120 -> 18000.
  - A=32'hFFFFFFFF, B=1 -> 40'h00000FFFFF (upper operand bits ignored).
- **Mode switch.** Go from `Sel`=0, A=10, B=0 to `Sel`=1, A=0, B=0 on consecutive cycles.
  - -> `Result` sequence is 10 then 0, with no intermediate value.
- **Equivalence.** Instantiate VARIANT 1, 2 and 3 side by side and drive all of the above plus random A/B/`Sel` for 10k cycles.
  - -> all `Result` outputs are identical every cycle and match the reference model above.
